// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector (Moore, one-cycle latency)
// with overlap control, valid qualification and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int               FW        = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_MAX  = FW'(PAT_LEN);
    localparam logic [FW-1:0]    FILL_THR  = FW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONES  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;

    logic [PAT_LEN-1:0] shifted;
    logic               match;
    logic [CNT_W-1:0]   cnt_next;
    logic               sat_next;

    // fill counts only bits since the last reset/load/non-overlap match, so
    // stale history (e.g. reset zeros) can never complete a pattern.
    assign shifted = {hist[PAT_LEN-2:0], in};
    assign match   = in_valid && !pat_load && (fill >= FILL_THR) && (shifted == pat_reg);

    // Clear takes priority, then a coincident match counts from zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_next = match_cnt;
        sat_next = cnt_sat;
        if (cnt_clr) begin
            cnt_next = match ? CNT_ONE : '0;
            sat_next = match && (CNT_ONE == CNT_ONES);
        end else if (match && (match_cnt != CNT_ONES)) begin
            cnt_next = match_cnt + CNT_ONE;
            sat_next = cnt_sat || ((match_cnt + CNT_ONE) == CNT_ONES);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            pat_reg   <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            out       <= match;
            match_cnt <= cnt_next;
            cnt_sat   <= sat_next;
            if (pat_load) begin
                pat_reg <= pat_in;
                hist    <= '0;
                fill    <= '0;
            end else if (in_valid) begin
                hist <= shifted;
                if (match && !overlap)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2)
// share stimulus; a bit-history model predicts outputs each cycle.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       cnt_clr = 1'b0;

    logic       out_a, sat_a, out_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit     out;
        int     cnt_a;
        bit     sat_a;
        int     cnt_b;
        bit     sat_b;
    } exp_t;

    exp_t sb[$];

    // model state
    bit [3:0] m_pat;
    bit       m_bits[$];
    int       m_cnt_a, m_cnt_b;
    bit       m_sat_a, m_sat_b;

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic count(inout int cnt, inout bit sat, input int max, input bit hit, input bit clr);
        if (clr) begin
            cnt = hit ? 1 : 0;
            sat = (cnt == max);
        end else if (hit && cnt < max) begin
            cnt++;
            if (cnt == max) sat = 1'b1;
        end
    endtask

    // Apply one cycle of stimulus and record the expected post-edge outputs.
    task automatic step(input bit r, input bit v, input bit b, input bit ov,
                        input bit ld, input bit [3:0] pin, input bit clr);
        exp_t e;
        bit   hit;
        int   win;
        @(negedge clk);
        rst = r; in_valid = v; in = b; overlap = ov;
        pat_load = ld; pat_in = pin; cnt_clr = clr;
        hit = 1'b0;
        if (r) begin
            m_pat = 4'b1011;
            m_bits.delete();
            m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 0; m_sat_b = 0;
        end else begin
            if (ld) begin
                m_pat = pin;
                m_bits.delete();
            end else if (v) begin
                m_bits.push_back(b);
                if (m_bits.size() > 4) void'(m_bits.pop_front());
                if (m_bits.size() == 4) begin
                    win = 0;
                    foreach (m_bits[i]) win = win * 2 + int'(m_bits[i]);
                    hit = (win == int'(m_pat));
                end
                if (hit && !ov) m_bits.delete();
            end
            count(m_cnt_a, m_sat_a, 255, hit, clr);
            count(m_cnt_b, m_sat_b, 3, hit, clr);
        end
        e.out = hit;
        e.cnt_a = m_cnt_a; e.sat_a = m_sat_a;
        e.cnt_b = m_cnt_b; e.sat_b = m_sat_b;
        sb.push_back(e);
    endtask

    task automatic bits(input bit [31:0] seq, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(0, 1, seq[i], ov, 0, 4'h0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 4'h0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 1, 0, 4'h0, 0);
    endtask

    // Monitor: outputs are presented every cycle; compare 1 ns after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("out_a", int'(out_a), int'(e.out));
                check("out_b", int'(out_b), int'(e.out));
                check("match_cnt_a", int'(cnt_a), e.cnt_a);
                check("cnt_sat_a", int'(sat_a), int'(e.sat_a));
                check("match_cnt_b", int'(cnt_b), e.cnt_b);
                check("cnt_sat_b", int'(sat_b), int'(e.sat_b));
            end
        end
    end

    initial begin
        do_reset();
        do_reset();
        // default pattern, overlapping
        bits(32'b1011, 4, 1);
        idle(2);
        // overlap vs non-overlap
        do_reset();
        bits(32'b1011011, 7, 1);
        do_reset();
        bits(32'b1011011, 7, 0);
        idle(1);
        // valid gaps
        do_reset();
        bits(32'b10, 2, 1);
        idle(3);
        bits(32'b11, 2, 1);
        idle(1);
        // pattern reload mid-stream, coincident valid bit ignored
        do_reset();
        bits(32'b101, 3, 1);
        step(0, 1, 1, 1, 1, 4'b0110, 0);
        bits(32'b1, 1, 1);
        bits(32'b0110, 4, 1);
        step(0, 0, 0, 1, 1, 4'b0000, 0);
        bits(32'b0000, 4, 1);
        bits(32'b00, 2, 1);
        // counter saturation (CNT_W=2), clear alone, clear with match
        do_reset();
        bits(32'b1011_1011_1011_1011, 16, 1);
        step(0, 0, 0, 1, 0, 4'h0, 1);
        bits(32'b101, 3, 1);
        step(0, 1, 1, 1, 0, 4'h0, 1);
        idle(1);
        // reset mid-operation
        step(0, 0, 0, 1, 1, 4'b0110, 0);
        bits(32'b101, 3, 1);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        bits(32'b1, 1, 1);
        bits(32'b1011, 4, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, v, b, ov, ld, clr;
            bit [3:0] pin;
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom_range(0, 1));
            ov  = ($urandom_range(0, 4) != 0);
            ld  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 59) == 0);
            pin = 4'($urandom_range(0, 15));
            step(r, v, b, ov, ld, pin, clr);
        end
        idle(3);
        repeat (4) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised, runtime-programmable serial bit-pattern detector, Moore style. It is the successor to the fixed 4-bit pattern detector.
- Pattern length and reset pattern are parameters; pattern is reloadable at runtime.
- Overlapping and non-overlapping detection are both supported.
- Input is qualified by a valid strobe.
- A saturating match counter is provided.
Sits on serial data/control lines (frame-sync, preamble and marker detection) in front of downstream control FSMs.

Parameters:
PAT_LEN, 4, pattern length in bits (legal range 2..32).
PATTERN, 4'b1011, pattern loaded at reset. MSB is the first bit received in time.
CNT_W, 8, width of the match counter (>=1).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  qualifies in; bit consumed only when high
in  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in into pattern register
pat_in  input  PAT_LEN  new pattern (MSB first in time)
cnt_clr  input  1  clear match counter and saturation flag
out  output  1  registered detect pulse
match_cnt  output  CNT_W  number of detections, saturating
cnt_sat  output  1  sticky flag, match_cnt reached all-ones

Behaviour:
- Reset (rst=1 at clock edge) overrides every other input in that cycle:
  - pat_reg<=PATTERN, hist<=0, fill<=0
  - out<=0, match_cnt<=0, cnt_sat<=0
- Internal state:
  - hist[PAT_LEN-1:0]: shift register; new bit enters LSB, oldest bit is at MSB.
  - fill: count of valid bits since last reset, load or non-overlap match. Saturates at PAT_LEN; width ceil(log2(PAT_LEN+1)).
- Consume (in_valid=1, pat_load=0): hist<={hist[PAT_LEN-2:0],in}; fill<=min(fill+1,PAT_LEN).
- Match (combinational, same cycle as consume): in_valid=1, pat_load=0, fill>=PAT_LEN-1 and {hist[PAT_LEN-2:0],in}==pat_reg.
  - Bits preceding reset/load never contribute, so pattern 0000 cannot match reset zeros.
- On match:
  - out<=1 for exactly one cycle, i.e. the cycle after the completing bit's edge (Moore latency 1).
  - out<=0 in every other cycle, including in_valid=0 cycles.
- overlap=1 on match: hist and fill update normally, so the match tail may seed the next match.
- overlap=0 on match: fill<=0; hist still shifts but is ignored until refilled. Next detection needs PAT_LEN fresh bits.
- overlap is sampled at the match cycle; changing it mid-stream affects only subsequent matches.
- pat_load=1:
  - pat_reg<=pat_in, hist<=0, fill<=0.
  - in is ignored even if in_valid=1; no match that cycle, out<=0.
  - Partial progress on the old pattern is discarded.
- Counter:
  - On match, match_cnt<=match_cnt+1 unless already all-ones (then holds). It updates on the same edge out rises.
  - cnt_sat<=1 when match_cnt becomes all-ones; sticky.
  - cnt_clr=1: match_cnt<=0, cnt_sat<=0. If a match occurs in the same cycle, match_cnt<=1 and cnt_sat<=0 (clear then count; for CNT_W=1, cnt_sat<=1).
  - cnt_clr does not affect detection state.
- in_valid=0 cycles: hist, fill and pat_reg hold; out<=0.
- Back-to-back valid bits with overlap=1 may produce out high on consecutive cycles (e.g. pattern 11 on stream 111).
- No combinational path from inputs to outputs.

Test Plan:
1. Defaults, overlap=1. After rst, in=1,0,1,1 on consecutive valid cycles -> out=1 only in the cycle after the 4th bit; match_cnt=1; cnt_sat=0.
2. Stream 1,0,1,1,0,1,1:
   - overlap=1 -> out pulses after bit 4 and bit 7; match_cnt=2.
   - Repeat with overlap=0 after reset -> one pulse after bit 4; match_cnt=1.
3. in_valid gaps: bits 1,0 / 3 idle cycles / 1,1 -> single pulse one cycle after the last bit; out=0 during idle cycles; hist unchanged across the gap.
4. pat_load:
   - Mid-stream after 1,0,1, pat_load with pat_in=4'b0110 and in_valid=1, in=1 the same cycle -> no pulse.
   - Then 1 -> no pulse.
   - Then 0,1,1,0 -> pulse after final 0.
   - Pattern 0000 loaded, then three 0s -> no pulse; fourth 0 -> pulse.
5. CNT_W=2 with overlap=1 and repeated 1011 -> match_cnt 1,2,3,3 and cnt_sat=1 from the 3rd match. Then cnt_clr alone -> 0/0. cnt_clr coincident with a match -> match_cnt=1.
6. Reset mid-operation: load 4'b0110, send 1,0,1, assert rst for one cycle with in_valid=1, in=1, then send 1 -> no pulse; pat_reg back to 1011; all outputs 0 during and after reset.
